// File: rtl/led_pwm_breathe.sv
// led_pwm_breathe: multi-channel LED PWM driver with off / solid / blink /
// breathe modes. All channels share one PWM counter, one breathe ramp and one
// blink counter. Each channel latches its duty only at the PWM period boundary,
// so mode or level changes never produce a runt or stretched pulse.
// Optional build macro: LED_PWM_GAMMA_EN squares the breathe ramp to give a
// roughly perceptual-linear fade. Without it, the ramp is used linearly.

// Per-channel duty selection, boundary-latched duty register and compare.
module led_pwm_breathe_lane #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] level,
  input  logic [PWM_W-1:0] bramp,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             blink_on,
  input  logic             load,
  output logic             led
);
  logic [2*PWM_W-1:0] prod;
  logic [PWM_W-1:0]   target;
  logic [PWM_W-1:0]   duty;

  // Upper half of level*ramp scales the peak level by the breathe phase.
  assign prod = {{PWM_W{1'b0}}, level} * {{PWM_W{1'b0}}, bramp};

  // Target duty for the next PWM period, chosen by mode.
  always_comb begin
    target = '0;
    case (mode)
      2'b00:   target = '0;
      2'b01:   target = level;
      2'b10:   target = blink_on ? level : '0;
      default: target = PWM_W'(prod >> PWM_W);
    endcase
  end

  // Duty only changes on the last count of a period; output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      if (load) duty <= target;
      led <= (pwm_cnt < duty);
    end
  end
endmodule

// Top level: shared counters, breathe ramp, sync pulse and the channel lanes.
module led_pwm_breathe #(
  parameter int NUM_CH    = 3,
  parameter int PWM_W     = 8,
  parameter int PRESC_DIV = 1024,
  parameter int BLINK_BIT = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*PWM_W-1:0] level,
  output logic [NUM_CH-1:0]       led,
  output logic                    sync
);
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESC_DIV - 1);
  localparam logic [PWM_W-1:0] TOP       = '1;
  localparam logic [PWM_W-1:0] ONE       = PWM_W'(1);

  logic [PWM_W-1:0]   pwm_cnt;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [PWM_W-1:0]   ramp;
  logic               dir_down;
  logic [BLINK_BIT:0] blink_cnt;
  logic [PWM_W-1:0]   bramp;
  logic               load;

  assign tick = (presc == PRESC_MAX);
  assign load = (pwm_cnt == TOP);

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_W-1:0] sq;
  // Squared ramp for a perceptually smoother fade.
  assign sq    = {{PWM_W{1'b0}}, ramp} * {{PWM_W{1'b0}}, ramp};
  assign bramp = PWM_W'(sq >> PWM_W);
`else
  assign bramp = ramp;
`endif

  // Free-running PWM, prescaler and blink counters; they run in every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt   <= '0;
      presc     <= '0;
      blink_cnt <= '0;
    end else begin
      pwm_cnt   <= pwm_cnt + ONE;
      presc     <= tick ? '0 : presc + PW'(1);
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Triangle ramp 0..TOP..0, turning around without dwelling at the ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp     <= '0;
      dir_down <= 1'b0;
    end else if (tick) begin
      if (!dir_down) begin
        ramp <= ramp + ONE;
        if (ramp == TOP - ONE) dir_down <= 1'b1;
      end else begin
        ramp <= ramp - ONE;
        if (ramp == ONE) dir_down <= 1'b0;
      end
    end
  end

  // Breathe-cycle start marker: follows the 1->0 step on the way down.
  always_ff @(posedge clk) begin
    if (rst) sync <= 1'b0;
    else     sync <= tick && dir_down && (ramp == ONE);
  end

  // One lane per channel; level and led split across the instance array.
  led_pwm_breathe_lane #(.PWM_W(PWM_W)) lane [NUM_CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .level    (level),
    .bramp    (bramp),
    .pwm_cnt  (pwm_cnt),
    .blink_on (blink_cnt[BLINK_BIT]),
    .load     (load),
    .led      (led)
  );
endmodule

// File: tb/tb_led_pwm_breathe.sv
// Bench for led_pwm_breathe at PWM_W=4, PRESC_DIV=2, BLINK_BIT=5, NUM_CH=3.
// Each observed PWM period is captured as a per-channel 16-bit high mask and
// compared against an expected mask taken from a scoreboard queue.
module tb_led_pwm_breathe;
  localparam int NUM_CH = 3, PWM_W = 4, PRESC_DIV = 2, BLINK_BIT = 5;
  localparam int PER = 1 << PWM_W;
  localparam int TRI = 2 * (PER - 1);
  localparam int BREATHE = TRI * PRESC_DIV;

  typedef logic [NUM_CH-1:0][PER-1:0]   masks_t;
  typedef logic [NUM_CH-1:0][PWM_W-1:0] lvls_t;
  typedef struct {
    logic [1:0] md;
    lvls_t      lv;
    masks_t     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'b01;
  logic [NUM_CH*PWM_W-1:0] level = '0;
  logic [NUM_CH-1:0] led;
  logic sync;

  led_pwm_breathe #(.NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC_DIV(PRESC_DIV),
                    .BLINK_BIT(BLINK_BIT)) dut (
    .clk(clk), .rst(rst), .mode(mode), .level(level), .led(led), .sync(sync));

  always #5 clk = ~clk;

  vec_t   vecs[5];
  masks_t sb_q[$];
  int checks = 0, failures = 0;
  int k = 0;         // clocks since reset release; equals the PWM phase mod PER
  int sync_cnt = 0, sync_k = 0;

  function automatic logic [PER-1:0] dm(int d);
    logic [31:0] t;
    t = (32'd1 << d) - 32'd1;
    return t[PER-1:0];
  endfunction

  function automatic int tri_ramp(int n);
    return (n <= PER - 1) ? n : TRI - n;
  endfunction

  function automatic int bduty(int lvl, int r);
    int g;
`ifdef LED_PWM_GAMMA_EN
    g = (r * r) >> PWM_W;
`else
    g = r;
`endif
    return (lvl * g) >> PWM_W;
  endfunction

  // One clock; sample #1 after the edge. Any sync pulse must land on a
  // multiple of the breathe period counted from reset release.
  task automatic step();
    @(posedge clk); #1;
    if (rst) k = 0; else k++;
    if (sync) begin
      sync_cnt++; sync_k = k; checks++;
      if (k == 0 || (k % BREATHE) != 0) begin
        failures++; $display("FAIL sync_phase: pulse at k=%0d, required multiple of %0d", k, BREATHE);
      end
    end
  endtask

  task automatic capture(output masks_t m);
    m = '0;
    for (int n = 0; n < PER; n++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) m[c][n] = led[c];
    end
  endtask

  task automatic chk(string name, masks_t got);
    masks_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL %s: got %h, scoreboard empty", name, got); return;
    end
    e = sb_q.pop_front();
    if (got !== e) begin
      failures++; $display("FAIL %s: got %h required %h", name, got, e);
    end
  endtask

  task automatic align();
    while ((k % PER) != 0) step();
  endtask

  // Capture np breathe periods; ramp at each load edge follows from k.
  task automatic breathe_periods(int np, lvls_t lv);
    masks_t m, e;
    int r;
    for (int p = 0; p < np; p++) begin
      r = tri_ramp(((k - 1) / PRESC_DIV) % TRI);
      for (int c = 0; c < NUM_CH; c++) e[c] = dm(bduty(int'(lv[c]), r));
      sb_q.push_back(e);
      capture(m);
      chk($sformatf("breathe_k%0d_r%0d", k - PER, r), m);
    end
  endtask

  initial begin
    masks_t m;
    lvls_t  lv;
    int     s0;

    vecs[0] = '{2'b01, {4'd15, 4'd0,  4'd4},  {dm(15), dm(0),  dm(4)}};
    vecs[1] = '{2'b01, {4'd14, 4'd8,  4'd1},  {dm(14), dm(8),  dm(1)}};
    vecs[2] = '{2'b01, {4'd0,  4'd7,  4'd15}, {dm(0),  dm(7),  dm(15)}};
    vecs[3] = '{2'b00, {4'd15, 4'd15, 4'd15}, {dm(0),  dm(0),  dm(0)}};
    vecs[4] = '{2'b01, {4'd12, 4'd3,  4'd9},  {dm(12), dm(3),  dm(9)}};

    // Reset held 3 cycles with solid full level.
    mode = 2'b01; level = {NUM_CH{4'd15}}; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (led !== '0 || sync !== 1'b0) begin
        failures++; $display("FAIL reset_hold: led=%b sync=%b required led=000 sync=0", led, sync);
      end
    end
    rst = 1'b0;
    sb_q.push_back('0);
    capture(m); chk("post_reset_period", m);
    sb_q.push_back({dm(15), dm(15), dm(15)});
    capture(m); chk("first_on_period", m);

    // Solid/off table.
    foreach (vecs[i]) begin
      align();
      mode = vecs[i].md; level = vecs[i].lv;
      sb_q.push_back(vecs[i].exp);
      repeat (PER) step();
      capture(m); chk($sformatf("vec%0d", i), m);
    end

    // Switch to off mid-period: current 10-wide pulse completes, then low.
    align();
    mode = 2'b01; level = {4'd0, 4'd0, 4'd10};
    repeat (PER) step();
    sb_q.push_back({dm(0), dm(0), dm(10)});
    m = '0;
    for (int n = 0; n < PER; n++) begin
      if (n == 5) mode = 2'b00;
      step();
      for (int c = 0; c < NUM_CH; c++) m[c][n] = led[c];
    end
    chk("mid_switch_cur", m);
    sb_q.push_back('0);
    capture(m); chk("mid_switch_next", m);

    // Blink: on when bit BLINK_BIT of the blink count at the load edge is 1.
    align();
    mode = 2'b10; level = {4'd0, 4'd15, 4'd8};
    repeat (PER) step();
    for (int p = 0; p < 4; p++) begin
      if ((((k - 1) >> BLINK_BIT) & 1) == 1) sb_q.push_back({dm(0), dm(15), dm(8)});
      else                                   sb_q.push_back('0);
      capture(m); chk($sformatf("blink_k%0d", k - PER), m);
    end

    // Breathe with sync pulse counting.
    align();
    lv = {4'd0, 4'd8, 4'd15};
    mode = 2'b11; level = lv;
    repeat (PER) step();
    s0 = k; sync_cnt = 0;
    breathe_periods(12, lv);
    checks++;
    if (sync_cnt != (k / BREATHE) - (s0 / BREATHE)) begin
      failures++; $display("FAIL sync_count: got %0d required %0d", sync_cnt, (k / BREATHE) - (s0 / BREATHE));
    end

    // Reset while the ramp is at 9 going down.
    for (int b = 0; b < 4 * BREATHE && ((k / PRESC_DIV) % TRI) != TRI - 9; b++) step();
    checks++;
    if (((k / PRESC_DIV) % TRI) != TRI - 9) begin
      failures++; $display("FAIL ramp9_wait: ticks=%0d required %0d", (k / PRESC_DIV) % TRI, TRI - 9);
    end
    rst = 1'b1;
    step(); step();
    checks++;
    if (led !== '0 || sync !== 1'b0) begin
      failures++; $display("FAIL mid_reset: led=%b sync=%b required 000/0", led, sync);
    end
    rst = 1'b0;
    sync_cnt = 0;
    sb_q.push_back('0);
    capture(m); chk("post_reset_breathe", m);
    while (sync_cnt == 0 && k < BREATHE + 40) step();
    checks++;
    if (sync_cnt != 1 || sync_k != BREATHE) begin
      failures++; $display("FAIL first_sync: count=%0d at k=%0d required 1 at k=%0d", sync_cnt, sync_k, BREATHE);
    end
    align();
    breathe_periods(4, lv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_pwm_breathe.md
# led_pwm_breathe

Parametrised multi-channel LED driver: per-channel PWM brightness with run-time selectable off / solid / blink / breathe modes. Sits between the on-chip oscillator clock and the RGB LED pins; replaces fixed counter-bit blinking with controllable duty, glitch-free mode switching and a breathing period sync output.

## Interface
- `NUM_CH`, 3: number of LED channels.
- `PWM_W`, 8: PWM resolution in bits; PWM period is 2^PWM_W clocks.
- `PRESC_DIV`, 1024: clocks per breathe ramp step; legal range ≥1.
- `BLINK_BIT`, 23: blink counter bit that gates blink mode; legal range ≥ PWM_W.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  00 off, 01 solid, 10 blink, 11 breathe; shared by all channels.
- `level`  in  NUM_CH*PWM_W  per-channel peak duty; channel i occupies bits [i*PWM_W +: PWM_W].
- `led`  out  NUM_CH  PWM outputs, active high, registered.
- `sync`  out  1  one-cycle pulse at each breathe-cycle start.

## Operation
- `pwm_cnt`: PWM_W-bit free-running counter, +1 every clock, wraps max→0.
- Prescaler: counts 0..PRESC_DIV-1; `tick` is asserted in the cycle it equals PRESC_DIV-1, then it returns to 0.
- Ramp: PWM_W-bit value plus direction bit, advanced only on `tick`. Up: +1; on reaching 2^PWM_W-1, direction flips to down. Down: −1; on reaching 0, direction flips to up. Never wraps or holds extra ticks at the ends; triangle period = 2*(2^PWM_W−1) ticks.
- Ramp, prescaler and blink counter run in every mode; entering breathe resumes at the current phase.
- Blink counter: BLINK_BIT+1 bits, free-running, wraps.
- Target duty per channel: off → 0; solid → level_i; blink → level_i when blink counter bit BLINK_BIT = 1, else 0; breathe → (level_i × ramp) >> PWM_W, meaning the upper PWM_W bits of the 2*PWM_W-bit product.
- Duty register per channel loads target duty only in the cycle `pwm_cnt` = 2^PWM_W−1. Changes to `mode` or `level` mid-period therefore never truncate or extend the current pulse.
- `led[i]` <= (`pwm_cnt` < duty_reg_i). Duty 0 → always low; duty 2^PWM_W−1 → high 2^PWM_W−1 of every 2^PWM_W cycles, so the output is never 100 % on.
- `sync` <= 1 for one cycle after the `tick` on which the ramp steps 1→0 while going down; otherwise 0.

## Timing
- Reset values: all counters 0, ramp 0, direction up, duty registers 0, `led` = 0, `sync` = 0.
- Reset mid-operation: all state returns to the reset values on the next edge. The first PWM period after reset release outputs 0.
- `led` latency: registered, one clock after the compare. New duty is first visible on `led` in the cycle after `pwm_cnt` returns to 0.
- `mode`/`level` to output latency: 1 to 2^PWM_W+1 clocks, depending on phase.
- Breathe period = 2*(2^PWM_W−1)*PRESC_DIV clocks. `sync` spacing equals this period exactly.
- `tick` coinciding with the PWM boundary: the duty register samples the ramp value from before that tick's update.
- `mode`/`level` are synchronous to `clk`; no internal input synchronisers.

## Configuration
- `LED_PWM_GAMMA_EN` defined: in breathe mode the ramp is first squared, g = (ramp × ramp) >> PWM_W, and duty = (level_i × g) >> PWM_W. This gives approximately perceptual-linear fade.
- Undefined: linear ramp as described in Operation; no squaring multiplier is synthesised.
- The macro has no effect on the off, solid or blink modes.

## Test plan
All scenarios use PWM_W=4, PRESC_DIV=2, BLINK_BIT=5, NUM_CH=3.
- Reset: `rst`=1 for 3 cycles with mode=01, level all 15 → `led`=000 and `sync`=0 throughout reset and for the 16 cycles after release. Then ch0 is high 15 of 16 cycles.
- Solid duty: mode=01, levels ch0=4, ch1=0, ch2=15 → ch0 high exactly 4 consecutive cycles per 16, ch1 never high, ch2 high 15 of 16.
- Mid-period switch: in solid with ch0=10, drive mode=00 at `pwm_cnt`=5 → ch0 completes its 10-cycle pulse, then stays low from the next period on.
- Blink: mode=10, ch0=8 → ch0 alternates two PWM periods of 8/16 duty with two periods fully low; pattern repeats every 64 clocks.
- Breathe: mode=11, ch0=15 → `sync` pulses every 60 clocks. At ramp=8, ch0 duty = 7 without the macro, or 3 with `LED_PWM_GAMMA_EN`.
- Reset mid-breathe: assert `rst` at ramp=9 going down → ramp=0 and direction up after release. The first `sync` arrives 60 clocks (one full period) after release.
